chroma_upsampler: RTL and testbench
===================================

# chroma_upsampler

Horizontal 2:1 chroma interpolation stage for milestone 1 of the decoder. It consumes packed 8-bit U or V samples as fetched from SRAM and produces, per chroma sample, the even (original) value and the odd (6-tap FIR-interpolated, clipped) value. These outputs feed the colour-space-conversion datapath that writes RGB back to SRAM for the VGA unit. One instance is used per chroma plane, and rows are processed back to back.

## Interface
Parameters:
- `ROW_SAMPLES`, default 160: chroma samples per row. Must be even and ≥ 6.

Ports:
- `CLOCK_50_I`, in, 1: 50 MHz clock. Only clock.
- `Resetn`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: `in_data` holds a valid word.
- `in_ready`, out, 1: word accepted on an edge where `in_valid && in_ready`.
- `in_data`, in, 16: two samples; `[15:8]` = even index k, `[7:0]` = k+1.
- `out_valid`, out, 1: output pair valid.
- `out_ready`, in, 1: pair consumed on an edge where `out_valid && out_ready`.
- `out_even`, out, 8: U[j].
- `out_odd`, out, 8: U'[2j+1], interpolated and clipped.
- `out_last`, out, 1: qualifies the pair with j = ROW_SAMPLES-1.

## Operation
- **Window.** W0..W5 holds U[j-2..j+3]. Indices below 0 clamp to U[0]; indices above N-1 clamp to U[N-1] (N = ROW_SAMPLES).
- **Pending byte.** `pend`/`pend_valid` holds the low byte of an accepted word until the window needs it.
- **S_FILL.**
  - `in_ready` = 1.
  - First word: W2 = W1 = W0 = hi, W3 = lo.
  - Second word: W4 = hi, W5 = lo. Window is now U0,U0,U0,U1,U2,U3. Set j = 0 and go to S_RUN.
- **S_RUN, fire condition.** A fire occurs when the output slot is free (`!out_valid || out_ready`) and the next sample is available. The next sample is available when any of these holds:
  - `pend_valid`;
  - `in_valid`, when a word is needed;
  - j+4 > N-1, in which case no sample is needed.
- **On fire:**
  - Output register ← {W2, clip(sum)}, `out_last` = (j == N-1).
  - Window shifts: W0..W4 ← W1..W5, W5 ← next sample. When j+4 > N-1, W5 ← W5 (replicates U[N-1]).
  - Next sample is `pend` if `pend_valid`, else the hi byte of the incoming word; that word's lo byte goes to `pend`.
  - j increments.
  - Fire at j == N-1 → S_FILL. The next row starts with an empty window.
- **`in_ready` in S_RUN.** Combinational: `!pend_valid && (j+4 ≤ N-1) && (!out_valid || out_ready)`.
- **Words per row.** Exactly N/2 words are accepted per row: 2 in S_FILL and (N-4)/2 in S_RUN.
- **Arithmetic.**
  - sum = 21·W0 − 52·W1 + 159·W2 + 159·W3 − 52·W4 + 21·W5 + 128.
  - Samples are unsigned; sum is signed 18-bit (range −26392..91928).
  - Result = sum >>> 8 (arithmetic shift). Values < 0 → 0; values > 255 → 255.
- **Clear on output.** `out_valid` clears on consume with no new fire.
- **Reset.** `Resetn` low on any edge, including mid-row: state = S_FILL, j = 0, `pend_valid` = 0, `out_valid` = 0, `out_even` = `out_odd` = 0, `out_last` = 0. Partial-row data is discarded.

## Timing
- **Reset values:** `out_valid` 0, `out_even` 0, `out_odd` 0, `out_last` 0. `in_ready` is 1 whenever `Resetn` is high and state is S_FILL.
- **Latency.** The window is valid after the edge accepting word 2. The first fire occurs in the next cycle, and `out_valid` is high after the following edge: 2 edges after the second word is accepted.
- **Throughput.** With `in_valid` and `out_ready` held high: one pair per cycle in S_RUN, one word every 2 cycles. The row takes 2 + N cycles in the block, plus a 1-cycle S_FILL gap before the next row's words.
- **Backpressure.** While `out_valid && !out_ready`: outputs stable, window frozen, `in_ready` = 0 in S_RUN.
- **Input stall.** A missing input only stalls fires; no output bubble is filled with stale data.

## Test plan
- **Flat row.** N = 160, all samples 128, no stalls → 160 pairs, each even = 128 and odd = 128; `out_last` only on the 160th; `in_ready` high for exactly 80 accepted words.
- **Ramp.** U[k] = k, N = 160:
  - j = 0 → (0, 0);
  - interior j → (j, j+1);
  - j = 158 → (158, 159);
  - j = 159 → (159, 159).
- **Step / clipping.** U[k] = 0 for k < 80, 255 otherwise:
  - j = 78 → odd 0 (raw −31);
  - j = 79 → odd 128;
  - j = 80 → odd 255 (raw 286).
- **Backpressure.** Ramp row; drop `out_ready` for 5 cycles at j = 40 → (40, 41) held stable for all 5 cycles, `in_ready` low throughout, sequence resumes at (41, 42) with no loss or duplication.
- **Input starvation and back-to-back rows.** Deassert `in_valid` for 7 cycles mid-row, then send two rows → no `out_valid` during the gap, and the second row's j = 0 output is computed from its own U0 only.
- **Reset mid-row.** Pulse `Resetn` low for 1 cycle at j = 50 → next edge has `out_valid` = 0 and outputs 0; the following row starts from S_FILL and matches the ramp expectations.

Source files
------------

// File: rtl/chroma_upsampler.sv
// -----------------------------------------------------------------------------
// chroma_upsampler
//
// Horizontal 2:1 chroma interpolation for one chroma plane (U or V). Packed
// sample pairs fetched from SRAM arrive on the input handshake. For every chroma
// sample U[j] of a row, one output pair is produced:
//   out_even = U[j]                        (original sample)
//   out_odd  = U'[2j+1]                    (6-tap FIR, rounded and clipped)
// Rows are processed back to back. Each row starts from an empty window.
//
// Parameters
//   ROW_SAMPLES  chroma samples per row (even, >= 6)
//
// Ports
//   CLOCK_50_I   50 MHz clock, the only clock
//   Resetn       synchronous active-low reset
//   in_valid     in_data holds a valid word
//   in_ready     word accepted on an edge with in_valid && in_ready
//   in_data      [15:8] = U[k] (even k), [7:0] = U[k+1]
//   out_valid    output pair valid
//   out_ready    pair consumed on an edge with out_valid && out_ready
//   out_even     U[j]
//   out_odd      interpolated U'[2j+1]
//   out_last     qualifies the pair with j == ROW_SAMPLES-1
// -----------------------------------------------------------------------------
module chroma_upsampler #(
    parameter int ROW_SAMPLES = 160
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_even,
    output logic [7:0]  out_odd,
    output logic        out_last
);

    // j runs 0..ROW_SAMPLES (it passes N on the final fire before refilling)
    localparam int J_W = $clog2(ROW_SAMPLES + 1);
    localparam logic [J_W-1:0] J_LAST     = J_W'(ROW_SAMPLES - 1);
    // From this j on, the window shift needs no new sample: j+4 > N-1
    localparam logic [J_W-1:0] J_NO_FETCH = J_W'(ROW_SAMPLES - 4);

    typedef enum logic {
        S_FILL,
        S_RUN
    } state_t;

    state_t         state_reg;
    logic           fill_second_reg;
    logic [J_W-1:0] j_reg;
    logic [7:0]     win_reg [0:5];      // U[j-2] .. U[j+3]
    logic [7:0]     pend_reg;
    logic           pend_valid_reg;

    logic           out_valid_reg;
    logic [7:0]     out_even_reg;
    logic [7:0]     out_odd_reg;
    logic           out_last_reg;

    logic           slot_free;
    logic           no_fetch;
    logic           fire;
    logic [7:0]     next_sample;

    logic signed [17:0] tap_prod [0:5];
    logic signed [17:0] fir_sum;
    logic signed [17:0] fir_shift;
    logic [7:0]         odd_clip;

    function automatic logic signed [17:0] tap_coef(input int idx);
        case (idx)
            0, 5:    return 18'sd21;
            1, 4:    return -18'sd52;
            default: return 18'sd159;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Handshake / fire decision
    // ------------------------------------------------------------------
    assign slot_free = !out_valid_reg || out_ready;
    assign no_fetch  = (j_reg >= J_NO_FETCH);

    // Outside S_RUN the block is always hungry. In S_RUN a word is only taken
    // when the pending byte has been used and the shift actually needs data.
    assign in_ready = (state_reg == S_FILL) ? 1'b1
                    : (!pend_valid_reg && !no_fetch && slot_free);

    assign fire = (state_reg == S_RUN) && slot_free &&
                  (pend_valid_reg || no_fetch || in_valid);

    // Past the right edge the window keeps replicating U[N-1], which already
    // sits in W5.
    assign next_sample = pend_valid_reg ? pend_reg
                       : no_fetch       ? win_reg[5]
                       : in_data[15:8];

    // ------------------------------------------------------------------
    // 6-tap FIR: samples are unsigned, so zero-extend before the signed MAC
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_tap
            assign tap_prod[gi] = $signed({10'd0, win_reg[gi]}) * tap_coef(gi);
        end
    endgenerate

    always_comb begin
        fir_sum = 18'sd128;             // rounding offset before the >>> 8
        for (int i = 0; i < 6; i++) begin
            fir_sum = fir_sum + tap_prod[i];
        end
    end

    assign fir_shift = fir_sum >>> 8;

    always_comb begin
        if (fir_sum[17]) begin
            odd_clip = 8'd0;
        end else if (fir_shift[17:8] != 10'd0) begin
            odd_clip = 8'hFF;
        end else begin
            odd_clip = fir_shift[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Control, window and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50_I) begin
        if (!Resetn) begin
            state_reg       <= S_FILL;
            fill_second_reg <= 1'b0;
            j_reg           <= '0;
            pend_valid_reg  <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_even_reg    <= 8'd0;
            out_odd_reg     <= 8'd0;
            out_last_reg    <= 1'b0;
        end else begin
            if (state_reg == S_FILL) begin
                if (in_valid) begin
                    if (!fill_second_reg) begin
                        // Left edge clamp: U[-2], U[-1] replicate U[0]
                        win_reg[0]      <= in_data[15:8];
                        win_reg[1]      <= in_data[15:8];
                        win_reg[2]      <= in_data[15:8];
                        win_reg[3]      <= in_data[7:0];
                        fill_second_reg <= 1'b1;
                    end else begin
                        win_reg[4]      <= in_data[15:8];
                        win_reg[5]      <= in_data[7:0];
                        fill_second_reg <= 1'b0;
                        j_reg           <= '0;
                        state_reg       <= S_RUN;
                    end
                end
            end else begin
                if (fire) begin
                    for (int i = 0; i < 5; i++) begin
                        win_reg[i] <= win_reg[i+1];
                    end
                    win_reg[5] <= next_sample;

                    if (pend_valid_reg) begin
                        pend_valid_reg <= 1'b0;
                    end else if (!no_fetch) begin
                        // Hi byte went straight into the window; park the lo byte
                        pend_reg       <= in_data[7:0];
                        pend_valid_reg <= 1'b1;
                    end

                    j_reg <= j_reg + J_W'(1);
                    if (j_reg == J_LAST) begin
                        state_reg <= S_FILL;
                    end
                end
            end

            if (fire) begin
                out_valid_reg <= 1'b1;
                out_even_reg  <= win_reg[2];
                out_odd_reg   <= odd_clip;
                out_last_reg  <= (j_reg == J_LAST);
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_even  = out_even_reg;
    assign out_odd   = out_odd_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_chroma_upsampler.sv
// -----------------------------------------------------------------------------
// Testbench for chroma_upsampler (ROW_SAMPLES = 160).
// Directed rows (flat, ramp, step, two back-to-back rows) are pushed through the
// input handshake while a collector drains and records output pairs. Each
// scenario task compares the recorded pairs against hand-computed values and a
// small clamped-window FIR reference.
// -----------------------------------------------------------------------------
module tb_chroma_upsampler;

    localparam int N  = 160;
    localparam int NW = N / 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_even;
    logic [7:0]  out_odd;
    logic        out_last;

    always #5 clk = ~clk;

    chroma_upsampler #(
        .ROW_SAMPLES(N)
    ) dut (
        .CLOCK_50_I(clk),
        .Resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_even  (out_even),
        .out_odd   (out_odd),
        .out_last  (out_last)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0] rows [0:1][0:N-1];
    logic [7:0] got_even [0:2*N-1];
    logic [7:0] got_odd  [0:2*N-1];
    logic       got_last [0:2*N-1];

    int  got_cnt;
    int  idle_cnt;
    int  bp_stable;
    int  bp_irl;
    int  words_acc;
    bit  col_timeout;
    bit  drv_timeout;
    bit  abort;

    // ---------------------------------------------------------------
    // Reference: clamped 6-tap FIR on the stored row
    // ---------------------------------------------------------------
    function automatic int u_at(input int r, input int k);
        int kk;
        kk = k;
        if (kk < 0) kk = 0;
        if (kk > N - 1) kk = N - 1;
        return int'(rows[r][kk]);
    endfunction

    function automatic logic [7:0] model_odd(input int r, input int j);
        int s;
        int q;
        s = 21 * u_at(r, j-2) - 52 * u_at(r, j-1) + 159 * u_at(r, j)
          + 159 * u_at(r, j+1) - 52 * u_at(r, j+2) + 21 * u_at(r, j+3) + 128;
        q = s >>> 8;
        if (q < 0)   return 8'd0;
        if (q > 255) return 8'd255;
        return 8'(q);
    endfunction

    // ---------------------------------------------------------------
    // Driver: one row of NW words, optional in_valid gap before word gap_word
    // ---------------------------------------------------------------
    task automatic send_row(input int r, input int gap_word, input int gap_len);
        int  wait_cyc;
        bit  accepted;
        words_acc = 0;
        for (int w = 0; w < NW && !abort && !drv_timeout; w++) begin
            if (w == gap_word) begin
                in_valid = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = {rows[r][2*w], rows[r][2*w+1]};
            wait_cyc = 0;
            accepted = 1'b0;
            while (!accepted && !abort && !drv_timeout) begin
                @(negedge clk);
                if (abort) break;
                if (in_ready) begin
                    accepted = 1'b1;
                    @(posedge clk);
                    #1;
                    words_acc++;
                end else begin
                    wait_cyc++;
                    if (wait_cyc > 2000) drv_timeout = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // ---------------------------------------------------------------
    // Collector: records n pairs; optionally withholds out_ready for
    // bp_len cycles when pair index bp_at is first presented.
    // ---------------------------------------------------------------
    task automatic collect(input int n, input int bp_at, input int bp_len);
        int          cyc;
        int          bp_left;
        bit          bp_done;
        bit          started;
        logic [16:0] held;
        got_cnt     = 0;
        idle_cnt    = 0;
        bp_stable   = 0;
        bp_irl      = 0;
        col_timeout = 1'b0;
        bp_left     = 0;
        bp_done     = 1'b0;
        started     = 1'b0;
        cyc         = 0;
        held        = '0;
        for (int i = 0; i < 2*N; i++) begin
            got_even[i] = 'x;
            got_odd[i]  = 'x;
            got_last[i] = 1'bx;
        end
        out_ready = 1'b1;
        while (got_cnt < n && !col_timeout) begin
            @(posedge clk);
            #2;
            cyc++;
            if (cyc > 4000) col_timeout = 1'b1;
            if (bp_left > 0) begin
                if (out_valid && ({out_even, out_odd, out_last} === held)) bp_stable++;
                if (in_ready === 1'b0) bp_irl++;
                bp_left--;
                if (bp_left == 0) out_ready = 1'b1;
            end
            if (bp_left == 0 && out_valid) begin
                if (got_cnt == bp_at && !bp_done) begin
                    held      = {out_even, out_odd, out_last};
                    bp_done   = 1'b1;
                    bp_left   = bp_len;
                    out_ready = 1'b0;
                end else begin
                    got_even[got_cnt] = out_even;
                    got_odd[got_cnt]  = out_odd;
                    got_last[got_cnt] = out_last;
                    got_cnt++;
                    started = 1'b1;
                end
            end else if (bp_left == 0 && started && !out_valid) begin
                idle_cnt++;
            end
        end
        $display("row transaction: %0d pairs, %0d words, %0d idle cycles", got_cnt, words_acc, idle_cnt);
    endtask

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (out_even !== 8'd0 || out_odd !== 8'd0) $display("FAIL reset_out_data: got (%0d,%0d) expected (0,0)", out_even, out_odd);
        else pass_cnt++;
        check_cnt++;
        if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last);
        else pass_cnt++;
        resetn = 1'b1;
        @(posedge clk);
        #2;
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_flat();
        int lasts;
        for (int k = 0; k < N; k++) rows[0][k] = 8'd128;
        fork
            send_row(0, -1, 0);
            collect(N, -1, 0);
        join
        check_cnt++;
        if (got_cnt !== N) $display("FAIL flat_count: got %0d pairs expected %0d", got_cnt, N);
        else pass_cnt++;
        check_cnt++;
        if (words_acc !== NW) $display("FAIL flat_words: got %0d words expected %0d", words_acc, NW);
        else pass_cnt++;
        check_cnt++;
        if (idle_cnt !== 0) $display("FAIL flat_throughput: got %0d idle cycles expected 0", idle_cnt);
        else pass_cnt++;
        lasts = 0;
        for (int i = 0; i < N; i++) begin
            if (got_last[i] === 1'b1) lasts++;
            check_cnt++;
            if (got_even[i] !== 8'd128 || got_odd[i] !== 8'd128)
                $display("FAIL flat_pair[%0d]: got (%0d,%0d) expected (128,128)", i, got_even[i], got_odd[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (lasts !== 1 || got_last[N-1] !== 1'b1)
            $display("FAIL flat_last: got %0d last flags (final=%b) expected 1 on pair %0d", lasts, got_last[N-1], N-1);
        else pass_cnt++;
    endtask

    task automatic test_ramp();
        for (int k = 0; k < N; k++) rows[0][k] = 8'(k);
        fork
            send_row(0, -1, 0);
            collect(N, -1, 0);
        join
        check_cnt++;
        if (got_cnt !== N) $display("FAIL ramp_count: got %0d expected %0d", got_cnt, N);
        else pass_cnt++;
        check_cnt++;
        if (got_even[0] !== 8'd0 || got_odd[0] !== 8'd0)
            $display("FAIL ramp_j0: got (%0d,%0d) expected (0,0)", got_even[0], got_odd[0]);
        else pass_cnt++;
        check_cnt++;
        if (got_even[10] !== 8'd10 || got_odd[10] !== 8'd11)
            $display("FAIL ramp_j10: got (%0d,%0d) expected (10,11)", got_even[10], got_odd[10]);
        else pass_cnt++;
        check_cnt++;
        if (got_even[100] !== 8'd100 || got_odd[100] !== 8'd101)
            $display("FAIL ramp_j100: got (%0d,%0d) expected (100,101)", got_even[100], got_odd[100]);
        else pass_cnt++;
        check_cnt++;
        if (got_even[158] !== 8'd158 || got_odd[158] !== 8'd159)
            $display("FAIL ramp_j158: got (%0d,%0d) expected (158,159)", got_even[158], got_odd[158]);
        else pass_cnt++;
        check_cnt++;
        if (got_even[159] !== 8'd159 || got_odd[159] !== 8'd159 || got_last[159] !== 1'b1)
            $display("FAIL ramp_j159: got (%0d,%0d,last=%b) expected (159,159,last=1)", got_even[159], got_odd[159], got_last[159]);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            check_cnt++;
            if (got_even[i] !== rows[0][i] || got_odd[i] !== model_odd(0, i) || got_last[i] !== (i == N-1))
                $display("FAIL ramp_pair[%0d]: got (%0d,%0d,%b) expected (%0d,%0d,%b)", i,
                         got_even[i], got_odd[i], got_last[i], rows[0][i], model_odd(0, i), (i == N-1));
            else pass_cnt++;
        end
    endtask

    task automatic test_step();
        for (int k = 0; k < N; k++) rows[0][k] = (k < 80) ? 8'd0 : 8'd255;
        fork
            send_row(0, -1, 0);
            collect(N, -1, 0);
        join
        check_cnt++;
        if (got_cnt !== N) $display("FAIL step_count: got %0d expected %0d", got_cnt, N);
        else pass_cnt++;
        check_cnt++;
        if (got_even[78] !== 8'd0 || got_odd[78] !== 8'd0)
            $display("FAIL step_j78_clip_low: got (%0d,%0d) expected (0,0)", got_even[78], got_odd[78]);
        else pass_cnt++;
        check_cnt++;
        if (got_even[79] !== 8'd0 || got_odd[79] !== 8'd128)
            $display("FAIL step_j79: got (%0d,%0d) expected (0,128)", got_even[79], got_odd[79]);
        else pass_cnt++;
        check_cnt++;
        if (got_even[80] !== 8'd255 || got_odd[80] !== 8'd255)
            $display("FAIL step_j80_clip_high: got (%0d,%0d) expected (255,255)", got_even[80], got_odd[80]);
        else pass_cnt++;
        check_cnt++;
        if (got_odd[10] !== 8'd0 || got_odd[120] !== 8'd255)
            $display("FAIL step_flat_regions: got (%0d,%0d) expected (0,255)", got_odd[10], got_odd[120]);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < N; k++) rows[0][k] = 8'(k);
        fork
            send_row(0, -1, 0);
            collect(N, 40, 5);
        join
        check_cnt++;
        if (got_cnt !== N) $display("FAIL bp_count: got %0d expected %0d", got_cnt, N);
        else pass_cnt++;
        check_cnt++;
        if (bp_stable !== 5) $display("FAIL bp_held_stable: got %0d stable cycles expected 5", bp_stable);
        else pass_cnt++;
        check_cnt++;
        if (bp_irl !== 5) $display("FAIL bp_in_ready_low: got %0d low cycles expected 5", bp_irl);
        else pass_cnt++;
        check_cnt++;
        if (got_even[40] !== 8'd40 || got_odd[40] !== 8'd41)
            $display("FAIL bp_j40: got (%0d,%0d) expected (40,41)", got_even[40], got_odd[40]);
        else pass_cnt++;
        check_cnt++;
        if (got_even[41] !== 8'd41 || got_odd[41] !== 8'd42)
            $display("FAIL bp_j41_resume: got (%0d,%0d) expected (41,42)", got_even[41], got_odd[41]);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            check_cnt++;
            if (got_even[i] !== rows[0][i] || got_odd[i] !== model_odd(0, i) || got_last[i] !== (i == N-1))
                $display("FAIL bp_pair[%0d]: got (%0d,%0d,%b) expected (%0d,%0d,%b)", i,
                         got_even[i], got_odd[i], got_last[i], rows[0][i], model_odd(0, i), (i == N-1));
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < N; k++) begin
            rows[0][k] = 8'(k);
            rows[1][k] = 8'(255 - k);
        end
        fork
            begin
                send_row(0, 30, 7);
                send_row(1, -1, 0);
            end
            collect(2*N, -1, 0);
        join
        check_cnt++;
        if (got_cnt !== 2*N) $display("FAIL b2b_count: got %0d expected %0d", got_cnt, 2*N);
        else pass_cnt++;
        check_cnt++;
        if (idle_cnt < 6) $display("FAIL b2b_starve_gap: got %0d idle cycles expected at least 6", idle_cnt);
        else pass_cnt++;
        check_cnt++;
        if (words_acc !== NW) $display("FAIL b2b_words_row2: got %0d expected %0d", words_acc, NW);
        else pass_cnt++;
        check_cnt++;
        if (got_even[N] !== 8'd255 || got_odd[N] !== 8'd255)
            $display("FAIL b2b_row2_j0: got (%0d,%0d) expected (255,255)", got_even[N], got_odd[N]);
        else pass_cnt++;
        for (int i = 0; i < 2*N; i++) begin
            int r;
            int j;
            r = (i < N) ? 0 : 1;
            j = (i < N) ? i : i - N;
            check_cnt++;
            if (got_even[i] !== rows[r][j] || got_odd[i] !== model_odd(r, j) || got_last[i] !== (j == N-1))
                $display("FAIL b2b_pair[%0d]: got (%0d,%0d,%b) expected (%0d,%0d,%b)", i,
                         got_even[i], got_odd[i], got_last[i], rows[r][j], model_odd(r, j), (j == N-1));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_row();
        for (int k = 0; k < N; k++) rows[0][k] = 8'(k);
        fork
            send_row(0, -1, 0);
            begin
                collect(50, -1, 0);
                @(posedge clk);
                #2;
                check_cnt++;
                if (out_valid !== 1'b1 || out_even !== 8'd50)
                    $display("FAIL midreset_pre_j50: got (valid=%b,even=%0d) expected (1,50)", out_valid, out_even);
                else pass_cnt++;
                resetn = 1'b0;
                abort  = 1'b1;
                @(posedge clk);
                #2;
                check_cnt++;
                if (out_valid !== 1'b0 || out_even !== 8'd0 || out_odd !== 8'd0 || out_last !== 1'b0)
                    $display("FAIL midreset_outputs: got (valid=%b,%0d,%0d,last=%b) expected (0,0,0,0)",
                             out_valid, out_even, out_odd, out_last);
                else pass_cnt++;
                resetn = 1'b1;
            end
        join
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fork
            send_row(0, -1, 0);
            collect(N, -1, 0);
        join
        check_cnt++;
        if (got_cnt !== N || words_acc !== NW)
            $display("FAIL midreset_row_count: got %0d pairs / %0d words expected %0d / %0d", got_cnt, words_acc, N, NW);
        else pass_cnt++;
        check_cnt++;
        if (got_even[0] !== 8'd0 || got_odd[0] !== 8'd0)
            $display("FAIL midreset_j0: got (%0d,%0d) expected (0,0)", got_even[0], got_odd[0]);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            check_cnt++;
            if (got_even[i] !== rows[0][i] || got_odd[i] !== model_odd(0, i) || got_last[i] !== (i == N-1))
                $display("FAIL midreset_pair[%0d]: got (%0d,%0d,%b) expected (%0d,%0d,%b)", i,
                         got_even[i], got_odd[i], got_last[i], rows[0][i], model_odd(0, i), (i == N-1));
            else pass_cnt++;
        end
    endtask

    initial begin
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_data     = 16'd0;
        out_ready   = 1'b1;
        abort       = 1'b0;
        drv_timeout = 1'b0;

        test_reset();
        test_flat();
        test_ramp();
        test_step();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_row();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
